turn_signal_sequencer: RTL and testbench

- Full left/right/hazard turn-signal controller for the DE2 board. It is the left-hand companion to the existing right blinker.
- Drives a 3-lamp chase on each side: left lamps on LEDR[2:0], right lamps on LEDG[2:0].
- Mode comes from slide switches.
- A free-running tick divider on CLOCK_50 sets the step rate. A Moore FSM advances one step per tick.

---
 rtl/turn_signal_sequencer.sv | 135 +++++++++++++
 tb/tb_turn_signal_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_sequencer.sv
// Left/right/hazard turn-signal controller: three-lamp chase per side, one
// step per divided tick, mode taken from synchronized slide switches.
module turn_signal_sequencer #(
  parameter int TICK_COUNT = 12500000,
  parameter int CNT_W      = 24
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [2:0] SW,
  output logic [2:0] LEDR,
  output logic [2:0] LEDG,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    L1   = 4'd1,
    L2   = 4'd2,
    L3   = 4'd3,
    L0   = 4'd4,
    R1   = 4'd5,
    R2   = 4'd6,
    R3   = 4'd7,
    R0   = 4'd8,
    HON  = 4'd9,
    HOFF = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       sw_meta;
  logic [2:0]       sw_s;
  req_t             req;
  state_t           state;
  state_t           next_state;

  // Free-running divider; mode changes never disturb its phase.
  assign tick = (cnt == CNT_W'(TICK_COUNT - 1));

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sw_meta <= 3'b000;
      sw_s    <= 3'b000;
    end else begin
      sw_meta <= SW;
      sw_s    <= sw_meta;
    end
  end

  // Both turn switches at once is treated as a hazard request.
  always_comb begin
    req = REQ_NONE;
    if (sw_s[2] || (sw_s[1] && sw_s[0])) begin
      req = REQ_HAZ;
    end else if (sw_s[1]) begin
      req = REQ_LEFT;
    end else if (sw_s[0]) begin
      req = REQ_RIGHT;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (req)
      REQ_LEFT: begin
        case (state)
          L1:      next_state = L2;
          L2:      next_state = L3;
          L3:      next_state = L0;
          default: next_state = L1;
        endcase
      end
      REQ_RIGHT: begin
        case (state)
          R1:      next_state = R2;
          R2:      next_state = R3;
          R3:      next_state = R0;
          default: next_state = R1;
        endcase
      end
      REQ_HAZ: begin
        next_state = (state == HON) ? HOFF : HON;
      end
      default: next_state = IDLE;
    endcase
  end

  function automatic logic [5:0] lamps(input state_t s);
    logic [5:0] l;
    l = 6'b000_000;
    case (s)
      L1:      l = 6'b001_000;
      L2:      l = 6'b011_000;
      L3:      l = 6'b111_000;
      R1:      l = 6'b000_001;
      R2:      l = 6'b000_011;
      R3:      l = 6'b000_111;
      HON:     l = 6'b111_111;
      default: l = 6'b000_000;
    endcase
    return l;
  endfunction

  // Lamps are registered from the next state so they always match the state register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      LEDR  <= 3'b000;
      LEDG  <= 3'b000;
    end else if (tick) begin
      state        <= next_state;
      {LEDR, LEDG} <= lamps(next_state);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Bench for turn_signal_sequencer: directed vector table, async reset
// sequence, and randomized switch/reset traffic against a behavioural model.
module tb_turn_signal_sequencer;

  localparam int TC = 4;

  logic       clk;
  logic       rst;
  logic [2:0] sw;
  logic [2:0] ledr;
  logic [2:0] ledg;
  logic [3:0] state_dbg;

  int n_chk;
  int n_err;
  bit chk_en;

  logic [5:0] exp_q[$];

  turn_signal_sequencer #(.TICK_COUNT(TC), .CNT_W(3)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw),
    .LEDR     (ledr),
    .LEDG     (ledg),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 none, 1 left, 2 right, 3 hazard; step counts ticks spent in mode.
  int         m_cnt;
  int         m_mode;
  int         m_step;
  logic [2:0] m_h1;
  logic [2:0] m_h2;

  function automatic int req_of(input logic [2:0] s);
    if (s[2] || (s[1] && s[0])) return 3;
    if (s[1]) return 1;
    if (s[0]) return 2;
    return 0;
  endfunction

  function automatic logic [5:0] model_lamps(input int mode, input int step);
    int n;
    logic [2:0] chase;
    n = (step + 1) % 4;
    chase = 3'((1 << n) - 1);
    case (mode)
      1:       return {chase, 3'b000};
      2:       return {3'b000, chase};
      3:       return (step == 0) ? 6'b111_111 : 6'b000_000;
      default: return 6'b000_000;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_mode <= 0;
      m_step <= 0;
      m_h1   <= 3'b000;
      m_h2   <= 3'b000;
    end else begin
      if (m_cnt == TC - 1) begin
        if (req_of(m_h2) == 0) begin
          m_mode <= 0;
          m_step <= 0;
        end else if (req_of(m_h2) == m_mode) begin
          m_step <= (m_step + 1) % ((m_mode == 3) ? 2 : 4);
        end else begin
          m_mode <= req_of(m_h2);
          m_step <= 0;
        end
      end
      m_cnt <= (m_cnt + 1) % TC;
      m_h1  <= sw;
      m_h2  <= m_h1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] e;
      e = model_lamps(m_mode, m_step);
      check("model_ledr", int'(ledr), int'(e[5:3]));
      check("model_ledg", int'(ledg), int'(e[2:0]));
      check("model_tick", int'(dut.tick), int'(m_cnt == TC - 1));
      check("invariant", int'((ledr != 3'b000) && (ledg != 3'b000) &&
                              !(ledr == 3'b111 && ledg == 3'b111)), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_release(input logic [2:0] v);
    sw  = v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] sw;
    int         ncyc;
    logic [2:0] ledr;
    logic [2:0] ledg;
  } vec_t;

  vec_t vecs[22];

  initial begin
    n_chk  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    sw     = 3'b000;
    rst    = 1'b1;

    vecs[0]  = '{3'b010, 4, 3'b001, 3'b000};
    vecs[1]  = '{3'b010, 4, 3'b011, 3'b000};
    vecs[2]  = '{3'b010, 4, 3'b111, 3'b000};
    vecs[3]  = '{3'b010, 4, 3'b000, 3'b000};
    vecs[4]  = '{3'b010, 4, 3'b001, 3'b000};
    vecs[5]  = '{3'b010, 4, 3'b011, 3'b000};
    vecs[6]  = '{3'b001, 4, 3'b000, 3'b001};
    vecs[7]  = '{3'b001, 4, 3'b000, 3'b011};
    vecs[8]  = '{3'b000, 4, 3'b000, 3'b000};
    vecs[9]  = '{3'b001, 4, 3'b000, 3'b001};
    vecs[10] = '{3'b001, 4, 3'b000, 3'b011};
    vecs[11] = '{3'b001, 4, 3'b000, 3'b111};
    vecs[12] = '{3'b001, 4, 3'b000, 3'b000};
    vecs[13] = '{3'b001, 4, 3'b000, 3'b001};
    vecs[14] = '{3'b011, 4, 3'b111, 3'b111};
    vecs[15] = '{3'b011, 4, 3'b000, 3'b000};
    vecs[16] = '{3'b011, 4, 3'b111, 3'b111};
    vecs[17] = '{3'b100, 4, 3'b000, 3'b000};
    vecs[18] = '{3'b100, 4, 3'b111, 3'b111};
    vecs[19] = '{3'b010, 4, 3'b001, 3'b000};
    vecs[20] = '{3'b010, 4, 3'b011, 3'b000};
    vecs[21] = '{3'b010, 4, 3'b111, 3'b000};

    // Idle run: lamps dark, tick on every fourth cycle.
    repeat (2) @(posedge clk);
    #1;
    check("reset_ledr", int'(ledr), 0);
    check("reset_ledg", int'(ledg), 0);
    chk_en = 1'b1;
    reset_release(3'b000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_tick", int'(dut.tick), int'((c % 4) == 3));
      check("idle_lamps", int'({ledr, ledg}), 0);
    end

    // Chase and mode-change vectors, starting from a fresh reset with SW=010.
    reset_release(3'b010);
    for (int i = 0; i < 22; i++) begin
      sw = vecs[i].sw;
      repeat (vecs[i].ncyc) @(posedge clk);
      @(negedge clk);
      exp_q.push_back({vecs[i].ledr, vecs[i].ledg});
      check($sformatf("vec%0d", i), int'({ledr, ledg}), int'(exp_q.pop_front()));
    end

    // In L3: reset must clear lamps without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("async_reset_ledr", int'(ledr), 0);
    check("async_reset_state", int'(state_dbg), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_reset_pre_tick", int'(ledr), 0);
    @(posedge clk);
    @(negedge clk);
    check("post_reset_l1", int'(ledr), 1);
    check("post_reset_ledg", int'(ledg), 0);

    // Randomized switch traffic with occasional reset pulses.
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #2 sw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #2 rst = 1'b0;
      end
      repeat ($urandom_range(1, 14)) @(posedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
